// File: rtl/circuit_a_exhaustive_driver_if.sv
// Stimulus/response bus between the exhaustive driver and a Circuit_A unit.
// The driver owns A..D and the unit answers on F.
interface circuit_a_exhaustive_driver_if;
   logic A;
   logic B;
   logic C;
   logic D;
   logic F;

   modport master (output A, B, C, D, input F);
   modport slave  (input A, B, C, D, output F);
endinterface

// File: rtl/circuit_a_exhaustive_driver.sv
// Sweeps all 16 {A,B,C,D} vectors into Circuit_A and scores F against EXP_MASK.
// Status outputs are registered from the state one edge late, so done follows the last sample by a cycle.
module circuit_a_exhaustive_driver #(
   parameter int          SETTLE   = 2,
   parameter logic [15:0] EXP_MASK = 16'hFDFD
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  abort,
   circuit_a_exhaustive_driver_if.master         unit,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic [4:0]                            err_count,
   output logic [15:0]                           result_vec,
   output logic [3:0]                            first_fail,
   output logic                                  fail_valid
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef struct packed {
      logic        pass;
      logic [4:0]  err_count;
      logic [15:0] vec;
      logic [3:0]  first_fail;
      logic        fail_valid;
   } res_t;

   logic [1:0] state;
   logic [3:0] idx;
   logic [3:0] settle_cnt;
   logic [3:0] abcd_q;
   logic       busy_q;
   logic       done_q;
   res_t       res;
   logic       sweeping;
   logic       mismatch;

   assign sweeping = (state == S_DRIVE) || (state == S_SAMPLE);
   assign mismatch = (unit.F != EXP_MASK[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         abcd_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         res        <= '0;
      end else if (abort) begin
         // Results are kept so a partial sweep can still be inspected.
         state      <= S_IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         abcd_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         busy_q <= sweeping;
         done_q <= (state == S_DONE);
         abcd_q <= sweeping ? idx : 4'd0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  res        <= '0;
                  idx        <= '0;
                  settle_cnt <= '0;
                  state      <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST)
                  state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               res.vec[idx] <= unit.F;
               if (mismatch) begin
                  res.err_count <= res.err_count + 5'd1;
                  if (!res.fail_valid) begin
                     res.first_fail <= idx;
                     res.fail_valid <= 1'b1;
                  end
               end
               if (idx == 4'd15) begin
                  state <= S_DONE;
               end else begin
                  idx        <= idx + 4'd1;
                  settle_cnt <= '0;
                  state      <= S_DRIVE;
               end
            end
            default: begin
               // err_count already includes the final sample here.
               res.pass <= (res.err_count == 5'd0);
               state    <= S_IDLE;
            end
         endcase
      end
   end

   assign unit.A     = abcd_q[3];
   assign unit.B     = abcd_q[2];
   assign unit.C     = abcd_q[1];
   assign unit.D     = abcd_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = res.pass;
   assign err_count  = res.err_count;
   assign result_vec = res.vec;
   assign first_fail = res.first_fail;
   assign fail_valid = res.fail_valid;

endmodule

// File: doc/circuit_a_exhaustive_driver.md
# circuit_a_exhaustive_driver

Sequential stimulus and checker block for the 4-input combinational unit Circuit_A (F = ~D | C | B). On a start pulse it drives every one of the 16 {A,B,C,D} combinations onto the unit's inputs and samples the returned F. It compares each sample with a parameterised expected truth table and reports a captured response vector, an error count and the first failing index. It sits beside Circuit_A in lab/self-test builds and forms the driving end of that unit's A/B/C/D→F interface.

## Interface
- SETTLE, 2: cycles each vector is held before F is sampled; legal range 1..15.
- EXP_MASK, 16'hFDFD: expected F per index; bit i = expected F for {A,B,C,D} = i (A is MSB).
- clk  in  1  single rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  returns to IDLE from any state at the next edge; outputs are cleared as for reset, except result registers, which hold.
- F  in  1  response from the unit under test.
- A, B, C, D  out  1 each  stimulus to the unit; {A,B,C,D} = current index.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  valid while done = 1 and held afterwards; 1 iff err_count = 0.
- err_count  out  5  number of mismatching indices, range 0..16.
- result_vec  out  16  captured F; bit i = F sampled for index i.
- first_fail  out  4  lowest index that mismatched.
- fail_valid  out  1  1 once any mismatch is recorded in the current sweep.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: outputs A..D = 0 and busy = 0. On start = 1: clear err_count, result_vec, first_fail, fail_valid and pass; set idx = 0 and settle_cnt = 0; go to DRIVE.
- DRIVE: {A,B,C,D} = idx. settle_cnt increments each cycle. When settle_cnt = SETTLE-1, go to SAMPLE.
- SAMPLE: at the closing edge:
  - result_vec[idx] <= F.
  - On mismatch (F != EXP_MASK[idx]): err_count += 1. If fail_valid = 0, set first_fail <= idx and fail_valid <= 1.
  - If idx = 15, go to DONE. Otherwise idx += 1, settle_cnt = 0, go to DRIVE.
- DONE: done = 1 for one cycle. pass <= (err_count = 0), with the final sample already included. Go to IDLE.
- idx is 4 bits and never wraps inside a sweep; the terminal test is idx = 15.
- err_count is 5 bits so that 16 errors does not overflow.
- start while busy or in DONE is ignored; no queuing.
- If abort and start are asserted together, abort wins.
- Results persist in IDLE until the next accepted start.
- F is treated as already synchronous, with combinational settling covered by SETTLE.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE. A = B = C = D = 0, busy = 0, done = 0, pass = 0, err_count = 0, result_vec = 0, first_fail = 0, fail_valid = 0, idx = 0, settle_cnt = 0.
- Reset mid-sweep: immediate return to the reset values above; there is no partial-result retention.
- Edge labels: the edge that samples start is edge 0. busy is high from edge 1.
- Each vector occupies SETTLE + 1 cycles: SETTLE cycles in DRIVE, then 1 in SAMPLE.
- done is high during the cycle after edge 16·(SETTLE+1) + 1. With SETTLE = 2 that is the cycle following edge 49.
- busy falls in the same cycle that done rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Golden unit (F wired from a real Circuit_A), SETTLE = 2, start pulse:
  - done pulses once, 49 edges after start.
  - result_vec = 16'hFDFD, err_count = 0, pass = 1, fail_valid = 0.
- F tied to 1:
  - result_vec = 16'hFFFF, err_count = 2.
  - first_fail = 1, fail_valid = 1, pass = 0.
- F tied to 0:
  - err_count = 14, first_fail = 0, pass = 0, result_vec = 0.
- Vector ordering:
  - Monitor {A,B,C,D} during a run. It steps 0,1,…,15, each value held exactly 3 cycles.
  - A second start pulse issued mid-sweep is ignored: the sweep length is unchanged and done fires exactly once.
- rst_n pulsed low at idx = 7 during a sweep:
  - All outputs return to their reset values asynchronously, before the next clock edge.
  - A fresh start then completes with a normal golden result.
- abort asserted at idx = 4:
  - IDLE at the next edge, busy = 0, no done pulse.
  - err_count and result_vec hold their partial values until the next start.
  - SETTLE = 1 run afterwards: done arrives 33 edges after start.
